// File: rtl/usb3_ext_buf_stream_if.sv
// Signal bundle between the USB 3.0 core external buffer ports, the IN sink
// stream and the OUT source stream. The slave view is the adapter itself.
interface usb3_ext_buf_stream_if;
    logic [31:0] sink_data;
    logic        sink_valid;
    logic        sink_last;
    logic        sink_ready;

    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_request;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;

    logic [8:0]  buf_out_addr;
    logic [31:0] buf_out_q;
    logic [10:0] buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;

    logic [31:0] source_data;
    logic        source_valid;
    logic        source_last;
    logic        source_ready;

    logic        in_pending;

    modport slave (
        input  sink_data, sink_valid, sink_last,
        output sink_ready,
        output buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_request, buf_in_ready,
        output buf_in_commit, buf_in_commit_len,
        input  buf_in_commit_ack,
        output buf_out_addr,
        input  buf_out_q, buf_out_len, buf_out_hasdata,
        output buf_out_arm,
        input  buf_out_arm_ack,
        output source_data, source_valid, source_last,
        input  source_ready,
        output in_pending
    );

    modport master (
        output sink_data, sink_valid, sink_last,
        input  sink_ready,
        input  buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_request, buf_in_ready,
        input  buf_in_commit, buf_in_commit_len,
        output buf_in_commit_ack,
        input  buf_out_addr,
        output buf_out_q, buf_out_len, buf_out_hasdata,
        input  buf_out_arm,
        output buf_out_arm_ack,
        input  source_data, source_valid, source_last,
        output source_ready,
        input  in_pending
    );
endinterface

// File: rtl/usb3_ext_buf_stream.sv
// Adapter between the USB 3.0 core external endpoint buffers and two
// valid/ready word streams. IN: sink words are written straight into the core
// buffer and committed. OUT: a received packet is read word by word through a
// 2-entry FIFO (covering the one-cycle buffer read latency) and re-armed.
module usb3_ext_buf_stream #(
    parameter int MAX_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    usb3_ext_buf_stream_if.slave   bus
);
    typedef enum logic [1:0] {IN_IDLE, IN_FILL, IN_COMMIT} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_READ, OUT_ARM} out_state_t;

    localparam logic [9:0] MAX_W = 10'(MAX_WORDS);

    // ---------------- IN path ----------------
    in_state_t   in_state_q, in_state_d;
    logic [8:0]  wc_q, wc_d;
    logic [10:0] clen_q, clen_d;
    logic        in_pending_q;
    logic        in_hs;
    logic [9:0]  wc_inc;

    assign in_hs  = (in_state_q == IN_FILL) && bus.sink_valid;
    assign wc_inc = {1'b0, wc_q} + 10'd1;

    // IN next-state: open buffer, count words, commit on last or length cap
    always_comb begin
        in_state_d = in_state_q;
        wc_d       = wc_q;
        clen_d     = clen_q;
        case (in_state_q)
            IN_IDLE: begin
                if (bus.buf_in_ready) begin
                    in_state_d = IN_FILL;
                    wc_d       = '0;
                end
            end
            IN_FILL: begin
                if (in_hs) begin
                    wc_d = wc_inc[8:0];
                    if (bus.sink_last || (wc_inc == MAX_W)) begin
                        in_state_d = IN_COMMIT;
                        clen_d     = {wc_inc[8:0], 2'b00};
                    end
                end
            end
            IN_COMMIT: begin
                if (bus.buf_in_commit_ack) in_state_d = IN_IDLE;
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // IN state, word counter, latched commit length and request status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state_q   <= IN_IDLE;
            wc_q         <= '0;
            clen_q       <= '0;
            in_pending_q <= 1'b0;
        end else begin
            in_state_q   <= in_state_d;
            wc_q         <= wc_d;
            clen_q       <= clen_d;
            in_pending_q <= bus.buf_in_request;
        end
    end

    assign bus.sink_ready        = (in_state_q == IN_FILL);
    assign bus.buf_in_wren       = in_hs;
    assign bus.buf_in_addr       = wc_q;
    assign bus.buf_in_data       = in_hs ? bus.sink_data : '0;
    assign bus.buf_in_commit     = (in_state_q == IN_COMMIT);
    assign bus.buf_in_commit_len = clen_q;
    assign bus.in_pending        = in_pending_q;

    // ---------------- OUT path ----------------
    out_state_t  out_state_q, out_state_d;
    logic [8:0]  nw_q, nw_d;
    logic [8:0]  raddr_q, raddr_d;
    logic        inflt_q, inflt_last_q;
    logic [31:0] fifo_data_q [2];
    logic [1:0]  fifo_last_q;
    logic        wptr_q, rptr_q;
    logic [1:0]  cnt_q;
    logic        pop, issue, issue_last;
    logic [1:0]  occ_after_pop, pending;
    logic [8:0]  nw_new;
    logic [1:0]  unused_len_lsb;

    // Word count is ceil(len/4) truncated to 9 bits
    assign {nw_new, unused_len_lsb} = bus.buf_out_len + 11'd3;

    // A word leaving this cycle frees its slot for a read issued this cycle,
    // which is what sustains one word per clock under continuous ready.
    assign pop           = (cnt_q != 2'd0) && bus.source_ready;
    assign occ_after_pop = cnt_q - {1'b0, pop};
    assign pending       = occ_after_pop + {1'b0, inflt_q};
    assign issue         = (out_state_q == OUT_READ) && (raddr_q != nw_q) && (pending < 2'd2);
    assign issue_last    = (raddr_q == nw_q - 9'd1);

    // OUT next-state: latch packet size, issue reads, re-arm after last word
    always_comb begin
        out_state_d = out_state_q;
        nw_d        = nw_q;
        raddr_d     = raddr_q;
        case (out_state_q)
            OUT_IDLE: begin
                if (bus.buf_out_hasdata) begin
                    nw_d        = nw_new;
                    raddr_d     = '0;
                    out_state_d = (nw_new == 9'd0) ? OUT_ARM : OUT_READ;
                end
            end
            OUT_READ: begin
                if (issue) raddr_d = raddr_q + 9'd1;
                if (pop && bus.source_last) out_state_d = OUT_ARM;
            end
            OUT_ARM: begin
                if (bus.buf_out_arm_ack) out_state_d = OUT_IDLE;
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // OUT state, packet word count and read address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state_q <= OUT_IDLE;
            nw_q        <= '0;
            raddr_q     <= '0;
        end else begin
            out_state_q <= out_state_d;
            nw_q        <= nw_d;
            raddr_q     <= raddr_d;
        end
    end

    // Read-return tracking and the 2-entry output FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflt_q        <= 1'b0;
            inflt_last_q   <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            cnt_q          <= '0;
        end else begin
            inflt_q      <= issue;
            inflt_last_q <= issue && issue_last;
            if (inflt_q) begin
                fifo_data_q[wptr_q] <= bus.buf_out_q;
                fifo_last_q[wptr_q] <= inflt_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, inflt_q} - {1'b0, pop};
        end
    end

    assign bus.source_valid = (cnt_q != 2'd0);
    assign bus.source_data  = fifo_data_q[rptr_q];
    assign bus.source_last  = bus.source_valid && fifo_last_q[rptr_q];
    assign bus.buf_out_addr = raddr_q;
    assign bus.buf_out_arm  = (out_state_q == OUT_ARM);
endmodule
